game_flow_sequencer: RTL
========================

# game_flow_sequencer

Frame-synchronous game controller that sequences the pixel colouriser and the game-logic block. It owns the top-level game state (title, countdown, play, dying, game over), drives the colouriser's `drawingState` and `gameOverFlag`, and issues the per-move tick to the game brain. The move rate speeds up as score rises. All visible state changes occur only on frame boundaries, so a frame never shows two game states.

## Interface
Parameters:
- `FRAMES_PER_SEC`, 60: frame_start pulses per second.
- `COUNTDOWN_SEC`, 3: countdown length in seconds, range 1–3.
- `START_PERIOD`, 8: frames per move at score 0, range 2–15.
- `MIN_PERIOD`, 2: fastest frames per move, range 1 to START_PERIOD.
- `SPEEDUP_EVERY`, 4: apples per one-frame period reduction, power of two.
- `DYING_FRAMES`, 30: length of the DYING phase in frames.

Ports (reset is asynchronous and active-high; every output below is registered):
- `clk` in 1: system/pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse on the first cycle of vertical blank.
- `start_btn` in 1: level input, already synchronised to `clk`.
- `collision` in 1: one-cycle pulse from the game brain.
- `apple_eaten` in 1: one-cycle pulse from the game brain.
- `drawingState` out 4: 0 TITLE, 1 COUNTDOWN, 2 PLAY, 3 DYING, 4 GAME_OVER.
- `gameOverFlag` out 1: high in DYING and GAME_OVER.
- `move_tick` out 1: one-cycle pulse telling the game brain to advance one step.
- `score` out 8: apples eaten this game; saturates at 255.
- `countdown_digit` out 2: seconds remaining in COUNTDOWN (3, 2, 1); 0 in every other state.

## Operation
- Reset values: state TITLE, `drawingState`=0, `gameOverFlag`=0, `move_tick`=0, `score`=0, `countdown_digit`=0. All counters and pending flags are cleared.
- Event capture:
  - A rising edge of `start_btn` sets `start_pend`. `collision` sets `coll_pend`. `apple_eaten` sets `apple_pend`. Each of these is sticky.
  - Pending flags are consumed, and all state transitions happen, only on an edge where `frame_start` is sampled high.
  - Events arriving on that same edge are kept for the next frame.
- TITLE: when `start_pend` is set, go to COUNTDOWN. On entry, clear `score`, `start_pend` and `coll_pend`, and load the countdown to COUNTDOWN_SEC×FRAMES_PER_SEC frames.
- COUNTDOWN:
  - The counter decrements once per frame.
  - `countdown_digit` = ceil(remaining / FRAMES_PER_SEC).
  - At 0, go to PLAY with the frame counter at 0.
  - `start_pend` and `coll_pend` are discarded.
- PLAY, per frame:
  - If `apple_pend` is set, `score` increments (saturating) and the flag clears.
  - If `coll_pend` is set, go to DYING. If both flags are set in the same frame, the score still increments, then the state goes to DYING.
  - Otherwise the frame counter increments. When it reaches period−1 it wraps to 0 and `move_tick` pulses.
  - period = max(MIN_PERIOD, START_PERIOD − score/SPEEDUP_EVERY). Compute it in 8 bits, and clamp before subtracting so the result cannot underflow.
  - `start_pend` is ignored.
- DYING: counts DYING_FRAMES frames, then goes to GAME_OVER. No `move_tick` is issued. `score` is held.
- GAME_OVER: `score` is held. When `start_pend` is set, go straight to COUNTDOWN; the score is cleared on entry.
- Encodings 5–15 on `drawingState` are never driven. An illegal internal state recovers to TITLE on the next frame.

## Timing
- On the edge that samples `frame_start`=1, state and counters update, so `drawingState` and `gameOverFlag` change the cycle after the pulse.
- `move_tick` is high for exactly the one cycle after that `frame_start` edge. There is at most one tick per frame.
- The new period applies starting with the frame after the score update.
- Event-to-effect latency: from the event up to the first `frame_start` edge after it, plus 1 cycle.
- `rst` asserted mid-frame clears all outputs immediately (asynchronously). After `rst` deasserts, the first `frame_start` is handled normally.
- Back-to-back `frame_start` pulses are legal; each counts as one frame.

## Structure
- Shared package `game_pkg`: state encoding localparams (TITLE…GAME_OVER, 4-bit) used here and by the colouriser/brain, and the score width (8).
- One natural sub-module, `move_period_timer`. It contains the frame counter, the period computation and `move_tick` generation. Inputs: `clk`, `rst`, `enable`, `frame_start`, `score`. Output: `move_tick`.
- Top level: the state machine, the event-capture flags and the countdown/dying counters.

## Test plan
- Reset, then 5 frames with no input → `drawingState`=0, all outputs 0, no `move_tick`.
- `start_btn` rises mid-frame → COUNTDOWN the cycle after the next `frame_start`. `countdown_digit` reads 3/2/1 for 60 frames each. PLAY after 180 frames.
- PLAY at score 0 → `move_tick` every 8th frame. Inject 24 apples → period reaches 2, and stays 2 at score 40.
- `collision` and `apple_eaten` in the same frame at score 5 → `score`=6, DYING; after 30 frames GAME_OVER with `gameOverFlag`=1 and no ticks.
- GAME_OVER, press start → COUNTDOWN with `score`=0. Hold the button high throughout → no second start is registered.
- Assert `rst` mid-PLAY, between frame pulses → all outputs 0 in the same cycle; next frame shows TITLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-state encoding and score width for the sequencer, colouriser and game brain.
package game_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_TITLE     = 4'd0,
    ST_COUNTDOWN = 4'd1,
    ST_PLAY      = 4'd2,
    ST_DYING     = 4'd3,
    ST_GAME_OVER = 4'd4
  } game_state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/move_period_timer.sv
// Frame counter that pulses move_tick once every `period` frames; period shrinks with score.
module move_period_timer
  import game_pkg::*;
#(
  parameter int unsigned START_PERIOD  = 8,
  parameter int unsigned MIN_PERIOD    = 2,
  parameter int unsigned SPEEDUP_EVERY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] score,
  output logic               move_tick
);

  localparam int unsigned SHIFT = $clog2(SPEEDUP_EVERY);
  localparam logic [SCORE_W-1:0] START_P = SCORE_W'(START_PERIOD);
  localparam logic [SCORE_W-1:0] MIN_P   = SCORE_W'(MIN_PERIOD);
  localparam logic [SCORE_W-1:0] SPAN    = SCORE_W'(START_PERIOD - MIN_PERIOD);

  logic [SCORE_W-1:0] steps;
  logic [SCORE_W-1:0] period;
  logic [SCORE_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               move_tick_q, move_tick_d;

  // Clamp against the span first so the subtraction never underflows.
  assign steps  = score >> SHIFT;
  assign period = (steps >= SPAN) ? MIN_P : START_P - steps;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    move_tick_d = 1'b0;
    if (!enable) begin
      frame_cnt_d = '0;
    end else if (frame_start) begin
      if (frame_cnt_q >= period - SCORE_W'(1)) begin
        frame_cnt_d = '0;
        move_tick_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + SCORE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      move_tick_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      move_tick_q <= move_tick_d;
    end
  end

  assign move_tick = move_tick_q;

endmodule

// File: rtl/game_flow_sequencer.sv
// Top-level game state machine: frame-synchronous transitions, sticky event capture, countdown/dying timing.
module game_flow_sequencer
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNTDOWN_SEC  = 3,
  parameter int unsigned START_PERIOD   = 8,
  parameter int unsigned MIN_PERIOD     = 2,
  parameter int unsigned SPEEDUP_EVERY  = 4,
  parameter int unsigned DYING_FRAMES   = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               start_btn,
  input  logic               collision,
  input  logic               apple_eaten,
  output logic [STATE_W-1:0] drawingState,
  output logic               gameOverFlag,
  output logic               move_tick,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         countdown_digit
);

  localparam int unsigned CD_FRAMES  = COUNTDOWN_SEC * FRAMES_PER_SEC;
  localparam int unsigned MAX_FRAMES = (CD_FRAMES > DYING_FRAMES) ? CD_FRAMES : DYING_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(CD_FRAMES);
  localparam logic [CNT_W-1:0] DY_LOAD = CNT_W'(DYING_FRAMES);

  game_state_e        state_q, state_d;
  logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_pend_q, start_pend_d;
  logic               coll_pend_q, coll_pend_d;
  logic               apple_pend_q, apple_pend_d;
  logic               btn_prev_q;
  logic [1:0]         digit_q, digit_d;
  logic [STATE_W-1:0] draw_q, draw_d;
  logic               gover_q, gover_d;
  logic [31:0]        remaining;

  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    score_d      = score_q;
    start_pend_d = start_pend_q;
    coll_pend_d  = coll_pend_q;
    apple_pend_d = apple_pend_q;
    digit_d      = 2'd0;
    remaining    = 32'd0;

    if (frame_start) begin
      case (state_q)
        ST_TITLE, ST_GAME_OVER: begin
          if (start_pend_q) begin
            state_d      = ST_COUNTDOWN;
            phase_cnt_d  = CD_LOAD;
            score_d      = '0;
            start_pend_d = 1'b0;
            coll_pend_d  = 1'b0;
          end
        end
        ST_COUNTDOWN: begin
          start_pend_d = 1'b0;
          coll_pend_d  = 1'b0;
          if (phase_cnt_q <= CNT_W'(1)) begin
            phase_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            phase_cnt_d = phase_cnt_q - CNT_W'(1);
          end
        end
        ST_PLAY: begin
          start_pend_d = 1'b0;
          if (apple_pend_q) begin
            score_d      = sat_inc(score_q);
            apple_pend_d = 1'b0;
          end
          if (coll_pend_q) begin
            state_d     = ST_DYING;
            phase_cnt_d = DY_LOAD;
            coll_pend_d = 1'b0;
          end
        end
        ST_DYING: begin
          if (phase_cnt_q <= CNT_W'(1)) begin
            phase_cnt_d = '0;
            state_d     = ST_GAME_OVER;
          end else begin
            phase_cnt_d = phase_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_TITLE;
      endcase
    end

    // Capture after consumption so events landing on the frame edge carry into the next frame.
    if (start_btn && !btn_prev_q) start_pend_d = 1'b1;
    if (collision)                coll_pend_d  = 1'b1;
    if (apple_eaten)              apple_pend_d = 1'b1;

    if (state_d == ST_COUNTDOWN) begin
      remaining = 32'(phase_cnt_d);
      if (remaining > 32'(2 * FRAMES_PER_SEC))  digit_d = 2'd3;
      else if (remaining > 32'(FRAMES_PER_SEC)) digit_d = 2'd2;
      else if (remaining != 32'd0)              digit_d = 2'd1;
    end

    draw_d  = (state_d > ST_GAME_OVER) ? ST_TITLE : state_d;
    gover_d = (state_d == ST_DYING) || (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_TITLE;
      phase_cnt_q  <= '0;
      score_q      <= '0;
      start_pend_q <= 1'b0;
      coll_pend_q  <= 1'b0;
      apple_pend_q <= 1'b0;
      btn_prev_q   <= 1'b0;
      digit_q      <= 2'd0;
      draw_q       <= '0;
      gover_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      score_q      <= score_d;
      start_pend_q <= start_pend_d;
      coll_pend_q  <= coll_pend_d;
      apple_pend_q <= apple_pend_d;
      btn_prev_q   <= start_btn;
      digit_q      <= digit_d;
      draw_q       <= draw_d;
      gover_q      <= gover_d;
    end
  end

  move_period_timer #(
    .START_PERIOD (START_PERIOD),
    .MIN_PERIOD   (MIN_PERIOD),
    .SPEEDUP_EVERY(SPEEDUP_EVERY)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     ((state_q == ST_PLAY) && !coll_pend_q),
    .frame_start(frame_start),
    .score      (score_q),
    .move_tick  (move_tick)
  );

  assign drawingState    = draw_q;
  assign gameOverFlag    = gover_q;
  assign score           = score_q;
  assign countdown_digit = digit_q;

endmodule
